pll_lock_sequencer: RTL and testbench

//  Supervises a PLL instance (e.g. the 6.6 MHz display PLL) from its 50 MHz refclk side.
//  - Pulses the PLL reset and waits for lock; retries on timeout.
//  - Holds the downstream clock-domain reset until lock has been stable for a set time.
//  - Detects lock loss, then re-sequences the PLL.
//  - Latches a fault after too many failed attempts.

---
 rtl/pll_lock_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses the PLL reset, waits for lock with timeout and retry,
// releases the downstream domain reset once lock is stable, re-sequences on lock loss.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  localparam int unsigned RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               clear_fault,
  output logic               pll_rst,
  output logic               domain_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned CNT_MAX_01 = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                       RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_01 > LOCK_STABLE_CYCLES) ?
                                       CNT_MAX_01 : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic [1:0]         sync_q;
  logic               sync_locked;
  logic               pll_rst_d, domain_rst_d, ready_d, fault_d, lock_lost_d;

  assign sync_locked = sync_q[1];

  // State register, synchronizer and registered output decode
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      sync_q      <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      domain_rst  <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[0], pll_locked};
      retry_count <= retry_d;
      pll_rst     <= pll_rst_d;
      domain_rst  <= domain_rst_d;
      ready       <= ready_d;
      fault       <= fault_d;
      lock_lost   <= lock_lost_d;
    end
  end

  // Next state, retry bookkeeping and decode of the state being entered
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_count;
    lock_lost_d  = 1'b0;
    cnt_d        = '0;
    pll_rst_d    = 1'b1;
    domain_rst_d = 1'b1;
    ready_d      = 1'b0;
    fault_d      = 1'b0;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (sync_locked) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_count + RETRY_W'(1);
            state_d = S_RESET_PLL;
          end
        end
      end
      S_STABILIZE: begin
        if (!sync_locked) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!sync_locked) begin
          state_d     = S_RESET_PLL;
          lock_lost_d = 1'b1;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = S_RESET_PLL;
    endcase

    // counter restarts on every state change and idles in RUN/FAULT
    if (state_d == state_q && state_q != S_RUN && state_q != S_FAULT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_d)
      S_WAIT_LOCK, S_STABILIZE: pll_rst_d = 1'b0;
      S_RUN: begin
        pll_rst_d    = 1'b0;
        domain_rst_d = 1'b0;
        ready_d      = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: phase/dwell reference model compared
// every cycle, directed scenarios with literal expectations, then random lock activity.
module tb_pll_lock_sequencer;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 20;
  localparam int STABLE    = 8;
  localparam int MAXR      = 2;

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       clear_fault;
  logic       pll_rst;
  logic       domain_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retry_count;

  int checks;
  int errors;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .LOCK_STABLE_CYCLES  (STABLE),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .clear_fault (clear_fault),
    .pll_rst     (pll_rst),
    .domain_rst  (domain_rst),
    .ready       (ready),
    .fault       (fault),
    .lock_lost   (lock_lost),
    .retry_count (retry_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: phase plus edges spent in it; lock seen two edges late
  int m_phase;
  int m_dwell;
  int m_retry;
  bit m_lost;
  bit m_valid;
  bit lk_q[$];
  bit m_sync;

  initial begin
    m_valid = 1'b0;
    m_phase = P_RST;
    m_dwell = 0;
    m_retry = 0;
    m_lost  = 1'b0;
    lk_q    = '{1'b0, 1'b0};
  end

  task automatic m_enter(input int p);
    m_phase = p;
    m_dwell = 0;
  endtask

  always @(posedge refclk) begin
    m_sync = lk_q[0];
    void'(lk_q.pop_front());
    lk_q.push_back(pll_locked);
    m_lost = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_retry = 0;
      lk_q    = '{1'b0, 1'b0};
      m_enter(P_RST);
    end else begin
      m_dwell++;
      case (m_phase)
        P_RST: if (m_dwell == RST_PULSE) m_enter(P_WAIT);
        P_WAIT: begin
          if (m_sync) m_enter(P_STAB);
          else if (m_dwell == TIMEOUT) begin
            if (m_retry == MAXR) m_enter(P_FAULT);
            else begin
              m_retry++;
              m_enter(P_RST);
            end
          end
        end
        P_STAB: begin
          if (!m_sync) m_enter(P_WAIT);
          else if (m_dwell == STABLE) begin
            m_retry = 0;
            m_enter(P_RUN);
          end
        end
        P_RUN: begin
          if (!m_sync) begin
            m_lost = 1'b1;
            m_enter(P_RST);
          end
        end
        default: begin
          if (clear_fault) begin
            m_retry = 0;
            m_enter(P_RST);
          end
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    if (m_valid) begin
      chk("model_pll_rst",    32'(pll_rst),     32'(m_phase == P_RST || m_phase == P_FAULT));
      chk("model_domain_rst", 32'(domain_rst),  32'(m_phase != P_RUN));
      chk("model_ready",      32'(ready),       32'(m_phase == P_RUN));
      chk("model_fault",      32'(fault),       32'(m_phase == P_FAULT));
      chk("model_lock_lost",  32'(lock_lost),   32'(m_lost));
      chk("model_retry",      32'(retry_count), 32'(m_retry));
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge refclk);
      compare_model();
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk({tag, "_pll_rst"},    32'(pll_rst),     32'd1);
    chk({tag, "_domain_rst"}, 32'(domain_rst),  32'd1);
    chk({tag, "_ready"},      32'(ready),       32'd0);
    chk({tag, "_fault"},      32'(fault),       32'd0);
    chk({tag, "_lock_lost"},  32'(lock_lost),   32'd0);
    chk({tag, "_retry"},      32'(retry_count), 32'd0);
  endtask

  initial begin
    int falls;
    bit prev;
    int kind;
    int len;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    pll_locked  = 1'b0;
    clear_fault = 1'b0;

    // T1 nominal: lock sampled at edge 10, ready after edge 20
    do_reset("t1_reset");
    step(3);
    chk("t1_pll_rst_edge2", 32'(pll_rst), 32'd1);
    step();
    chk("t1_pll_rst_edge3", 32'(pll_rst), 32'd0);
    step(6);
    pll_locked = 1'b1;
    step(10);
    chk("t1_ready_edge19", 32'(ready), 32'd0);
    step();
    chk("t1_ready_edge20",      32'(ready),       32'd1);
    chk("t1_domain_rst_edge20", 32'(domain_rst),  32'd0);
    chk("t1_retry",             32'(retry_count), 32'd0);

    // T2 never lock: three 4-cycle pulses, fault after edge 71
    pll_locked = 1'b0;
    do_reset("t2_reset");
    falls = 0;
    prev  = 1'b1;
    for (int i = 0; i < 72; i++) begin
      step();
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
      if (i == 70) chk("t2_fault_edge70", 32'(fault), 32'd0);
    end
    chk("t2_fault_edge71", 32'(fault),       32'd1);
    chk("t2_retry",        32'(retry_count), 32'd2);
    chk("t2_pll_rst_held", 32'(pll_rst),     32'd1);
    chk("t2_pulse_count",  32'(falls),       32'd3);
    step(10);
    chk("t2_fault_sticky", 32'(fault), 32'd1);

    // T3 lock drop mid-STABILIZE, relock sampled at edge 18 -> ready after edge 28
    do_reset("t3_reset");
    step(10);
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(10);
    chk("t3_ready_edge27", 32'(ready),       32'd0);
    chk("t3_retry",        32'(retry_count), 32'd0);
    step();
    chk("t3_ready_edge28", 32'(ready), 32'd1);

    // T4 lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    chk("t4_lock_lost_early", 32'(lock_lost), 32'd0);
    chk("t4_ready_early",     32'(ready),     32'd1);
    step();
    chk("t4_lock_lost",  32'(lock_lost),  32'd1);
    chk("t4_ready",      32'(ready),      32'd0);
    chk("t4_domain_rst", 32'(domain_rst), 32'd1);
    chk("t4_pll_rst",    32'(pll_rst),    32'd1);
    step();
    chk("t4_lock_lost_one_cycle", 32'(lock_lost), 32'd0);
    step(2);
    chk("t4_pll_rst_last", 32'(pll_rst), 32'd1);
    step();
    chk("t4_pll_rst_end", 32'(pll_rst), 32'd0);

    // T5 fault then clear_fault; clear_fault in RUN ignored
    step(68);
    chk("t5_fault", 32'(fault), 32'd1);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("t5_fault_cleared", 32'(fault),       32'd0);
    chk("t5_pll_rst",       32'(pll_rst),     32'd1);
    chk("t5_retry",         32'(retry_count), 32'd0);
    pll_locked = 1'b1;
    step(30);
    chk("t5_relock_ready", 32'(ready), 32'd1);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    step();
    chk("t5_clear_in_run_ready", 32'(ready), 32'd1);
    chk("t5_clear_in_run_fault", 32'(fault), 32'd0);

    // T6 reset mid-RUN and mid-STABILIZE
    do_reset("t6_reset_run");
    step(8);
    do_reset("t6_reset_stab");
    step(20);
    chk("t6_ready_after_restart", 32'(ready), 32'd1);

    // Random lock activity, clears and resets against the model
    for (int s = 0; s < 90; s++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 4) begin
        pll_locked = 1'b1;
        len = int'($urandom_range(1, 40));
      end else if (kind < 7) begin
        pll_locked = 1'b0;
        len = int'($urandom_range(1, 30));
      end else if (kind == 7) begin
        pll_locked = 1'b0;
        len = int'($urandom_range(60, 120));
      end else if (kind == 8) begin
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        len = int'($urandom_range(1, 10));
      end else begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        len = int'($urandom_range(1, 10));
      end
      step(len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
